// File: rtl/modular_addsub_unit.sv
// Modular add/subtract unit: (a+b) mod m or (a-b) mod m via a five-state FSM
// with a per-operation modulus snapshot; all outputs are registered.
module modular_addsub_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             modular_write_i,
  input  logic [WIDTH-1:0] modulo_i,
  input  logic             add_start_i,
  input  logic             sub_start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             add_finish_o,
  output logic [WIDTH-1:0] add_result_o,
  output logic             sub_finish_o,
  output logic [WIDTH-1:0] sub_result_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REDUCE,
    S_DONE,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] m_snap_q, m_snap_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_add_q, op_add_d;
  logic [WIDTH:0]   raw_q, raw_d;
  logic [WIDTH-1:0] add_res_q, add_res_d;
  logic [WIDTH-1:0] sub_res_q, sub_res_d;
  logic             add_fin_q, add_fin_d;
  logic             sub_fin_q, sub_fin_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   red_diff;

  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    m_snap_d  = m_snap_q;
    a_d       = a_q;
    b_d       = b_q;
    op_add_d  = op_add_q;
    raw_d     = raw_q;
    add_res_d = add_res_q;
    sub_res_d = sub_res_q;
    add_fin_d = 1'b0;
    sub_fin_d = 1'b0;
    red_diff  = raw_q - {1'b0, m_snap_q};

    // Snapshot takes mod_q before this edge's write, so a same-edge write only affects later ops
    if (modular_write_i) mod_d = modulo_i;

    unique case (state_q)
      S_IDLE: begin
        if (add_start_i || sub_start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          op_add_d = add_start_i;
          m_snap_d = mod_q;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (op_add_q) raw_d = {1'b0, a_q} + {1'b0, b_q};
        else          raw_d = {1'b0, a_q} - {1'b0, b_q};
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (op_add_q) begin
          if (raw_q >= {1'b0, m_snap_q}) add_res_d = red_diff[WIDTH-1:0];
          else                           add_res_d = raw_q[WIDTH-1:0];
          add_fin_d = 1'b1;
        end else begin
          // raw_q[WIDTH] is the borrow of a-b
          if (raw_q[WIDTH]) sub_res_d = raw_q[WIDTH-1:0] + m_snap_q;
          else              sub_res_d = raw_q[WIDTH-1:0];
          sub_fin_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = (add_start_i || sub_start_i) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!add_start_i && !sub_start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mod_q     <= '0;
      m_snap_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_add_q  <= 1'b0;
      raw_q     <= '0;
      add_res_q <= '0;
      sub_res_q <= '0;
      add_fin_q <= 1'b0;
      sub_fin_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mod_q     <= mod_d;
      m_snap_q  <= m_snap_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_add_q  <= op_add_d;
      raw_q     <= raw_d;
      add_res_q <= add_res_d;
      sub_res_q <= sub_res_d;
      add_fin_q <= add_fin_d;
      sub_fin_q <= sub_fin_d;
      busy_q    <= busy_d;
    end
  end

  assign add_finish_o = add_fin_q;
  assign add_result_o = add_res_q;
  assign sub_finish_o = sub_fin_q;
  assign sub_result_o = sub_res_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_modular_addsub_unit.sv
// Scoreboard bench for modular_addsub_unit: stimulus pushes hand-computed
// expectations, a monitor pops and checks them on every finish pulse.
module tb_modular_addsub_unit;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         modular_write_i = 1'b0;
  logic [W-1:0] modulo_i = '0;
  logic         add_start_i = 1'b0;
  logic         sub_start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         add_finish_o;
  logic [W-1:0] add_result_o;
  logic         sub_finish_o;
  logic [W-1:0] sub_result_o;
  logic         busy_o;

  modular_addsub_unit #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .modular_write_i(modular_write_i),
    .modulo_i       (modulo_i),
    .add_start_i    (add_start_i),
    .sub_start_i    (sub_start_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .add_finish_o   (add_finish_o),
    .add_result_o   (add_result_o),
    .sub_finish_o   (sub_finish_o),
    .sub_result_o   (sub_result_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         is_add;
    logic [W-1:0] val;
    int           fin_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_add = '0;
  logic [W-1:0] last_sub = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (add_finish_o || sub_finish_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_finish", {62'd0, add_finish_o, sub_finish_o}, '0);
        end else begin
          e = sb_q.pop_front();
          chk("finish_kind", {62'd0, add_finish_o, sub_finish_o},
              e.is_add ? 64'd2 : 64'd1);
          chk("latency", W'(cyc), W'(e.fin_cyc));
          if (e.is_add) begin
            chk("add_result", add_result_o, e.val);
            chk("sub_unchanged", sub_result_o, last_sub);
            last_add = e.val;
          end else begin
            chk("sub_result", sub_result_o, e.val);
            chk("add_unchanged", add_result_o, last_add);
            last_sub = e.val;
          end
        end
      end
    end
  end

  task automatic push(input logic is_add, input logic [W-1:0] val);
    exp_t e;
    e.is_add  = is_add;
    e.val     = val;
    e.fin_cyc = cyc + 3;
    sb_q.push_back(e);
  endtask

  task automatic write_mod(input logic [W-1:0] m);
    @(negedge clk);
    modular_write_i = 1'b1;
    modulo_i        = m;
    @(negedge clk);
    modular_write_i = 1'b0;
  endtask

  task automatic run_op(input logic add, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input logic [W-1:0] expv);
    @(negedge clk);
    a_i = a;
    b_i = b;
    add_start_i = add;
    sub_start_i = sub;
    push(add, expv);
    repeat (hold) @(negedge clk);
    add_start_i = 1'b0;
    sub_start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) break;
      @(negedge clk);
    end
    chk("wait_idle_timeout", {63'd0, busy_o}, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_add_result"}, add_result_o, '0);
    chk({tag, "_sub_result"}, sub_result_o, '0);
    chk({tag, "_finish"}, {62'd0, add_finish_o, sub_finish_o}, '0);
    chk({tag, "_busy"}, {63'd0, busy_o}, '0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_ni = 1'b1;

    // m = 97 add and sub
    write_mod(64'd97);
    run_op(1'b1, 1'b0, 64'd50, 64'd60, 1, 64'd13);
    wait_idle();
    run_op(1'b0, 1'b1, 64'd10, 64'd20, 1, 64'd87);
    wait_idle();
    run_op(1'b0, 1'b1, 64'd20, 64'd10, 1, 64'd10);
    wait_idle();

    // held start: single op, HOLD until release
    run_op(1'b1, 1'b0, 64'd1, 64'd2, 6, 64'd3);
    chk("hold_busy", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    chk("hold_release_idle", {63'd0, busy_o}, '0);

    // simultaneous starts plus same-edge modulus write
    write_mod(64'd11);
    @(negedge clk);
    a_i = 64'd5;
    b_i = 64'd9;
    add_start_i = 1'b1;
    sub_start_i = 1'b1;
    modular_write_i = 1'b1;
    modulo_i = 64'd7;
    push(1'b1, 64'd3);
    @(negedge clk);
    add_start_i = 1'b0;
    sub_start_i = 1'b0;
    modular_write_i = 1'b0;
    wait_idle();
    run_op(1'b1, 1'b0, 64'd5, 64'd4, 1, 64'd2);
    wait_idle();

    // m = 0 wraps mod 2^64
    write_mod(64'd0);
    run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 64'd1);
    wait_idle();
    run_op(1'b0, 1'b1, 64'd0, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();

    // reset while in REDUCE aborts without a finish pulse
    write_mod(64'd97);
    @(negedge clk);
    a_i = 64'd50;
    b_i = 64'd60;
    add_start_i = 1'b1;
    @(negedge clk);
    add_start_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    last_add = '0;
    last_sub = '0;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("abort_no_late_finish", {62'd0, add_finish_o, sub_finish_o}, '0);
    run_op(1'b1, 1'b0, 64'd4, 64'd5, 1, 64'd9);
    wait_idle();
    run_op(1'b1, 1'b0, 64'd60, 64'd50, 1, 64'd110);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sb_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modular_addsub_unit.md
MODULAR_ADDSUB_UNIT -- requirements
Module: modular_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result/modulus width.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port modular_write_i  input  1  load modulus register from modulo_i.
REQ-005 SHALL have port modulo_i  input  WIDTH  modulus value m.
REQ-006 SHALL have port add_start_i  input  1  level request for (a+b) mod m.
REQ-007 SHALL have port sub_start_i  input  1  level request for (a-b) mod m.
REQ-008 SHALL have port a_i  input  WIDTH  operand a.
REQ-009 SHALL have port b_i  input  WIDTH  operand b.
REQ-010 SHALL have port add_finish_o  output  1  one-cycle pulse, add result valid.
REQ-011 SHALL have port add_result_o  output  WIDTH  modular sum.
REQ-012 SHALL have port sub_finish_o  output  1  one-cycle pulse, sub result valid.
REQ-013 SHALL have port sub_result_o  output  WIDTH  modular difference.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, CALC, REDUCE, DONE, HOLD, all outputs registered.
REQ-016 SHALL, in IDLE with add_start_i or sub_start_i high at edge k, latch a_i, b_i, op and the current modulus register into a snapshot, and enter CALC.
REQ-017 SHALL give add priority when add_start_i and sub_start_i are both high in IDLE; sub request ignored.
REQ-018 SHALL, in CALC (edge k+1), compute raw = a+b as WIDTH+1 bits (add) or a-b with borrow flag (sub), and enter REDUCE.
REQ-019 SHALL, in REDUCE (edge k+2), add: result = raw-m if raw >= m (WIDTH+1-bit compare) else raw, truncated to WIDTH; sub: result = d+m (mod 2^WIDTH) if borrow else d; enter DONE.
REQ-020 SHALL assert the matching finish output for exactly the one cycle spent in DONE (visible after edge k+2); latency start-sampled to finish = 3 cycles.
REQ-021 SHALL update only the result port of the executed op at edge k+2; both result ports otherwise hold their last value.
REQ-022 SHALL, at DONE exit (edge k+3), go to HOLD if either start input is high, else IDLE.
REQ-023 SHALL stay in HOLD until both start inputs are low, then enter IDLE; a start held high SHALL never launch a second operation.
REQ-024 SHALL ignore start inputs in CALC, REDUCE, DONE, HOLD.
REQ-025 SHALL load modulus register from modulo_i on any edge with modular_write_i high, in any state.
REQ-026 SHALL use the snapshot modulus for an in-flight op; a write at or after edge k affects only later ops; write and start at the same edge: op uses old modulus.
REQ-027 SHALL, with m = 0, produce a+b mod 2^WIDTH and a-b mod 2^WIDTH (no special case).
REQ-028 SHALL guarantee correct modular results only for a, b < m; other inputs still yield the defined arithmetic of REQ-019, no error flag.

Reset
REQ-029 SHALL, when rst_ni low at an edge, enter IDLE and clear modulus register, snapshot, results, finish outputs and busy_o to 0.
REQ-030 SHALL abort an in-flight op on reset with no finish pulse; first op after reset follows REQ-016.

Verification
REQ-031 Write m=97; add_start with a=50,b=60 -> add_finish_o one cycle, 3 cycles after start, add_result_o=13, sub_result_o unchanged.
REQ-032 m=97; sub_start with a=10,b=20 -> sub_finish_o pulse, sub_result_o=87; a=20,b=10 -> 10.
REQ-033 add_start held high 6 cycles, a=1,b=2,m=97 -> exactly one finish pulse, result 3, FSM in HOLD until start drops, then IDLE.
REQ-034 add_start and sub_start together, a=5,b=9,m=11 -> only add_finish_o, add_result_o=3; modular_write m=7 on start edge -> still uses 11.
REQ-035 m=0: add a=2^64-1,b=2 -> 1; sub a=0,b=1 -> 2^64-1.
REQ-036 Reset asserted in REDUCE -> no finish pulse, all outputs 0, modulus 0; next add a=4,b=5 with m=0 -> 9.
